// File: rtl/simple_axi4_master_if.sv
// Host command/stream bus plus AXI4 master channels, bundled for the bridge.
// Latency: none, wires only.
// Backpressure: carries valid/ready pairs for every stream and AXI channel.
interface simple_axi4_master_if;
    // host side
    logic [31:0]  tcpBus_addr;
    logic [31:0]  tcpBus_size;
    logic         tcpBus_wdata_valid;
    logic         tcpBus_wdata_ready;
    logic         tcpBus_wdata_payload_last;
    logic [127:0] tcpBus_wdata_payload_fragment;
    logic         tcpBus_rdata_valid;
    logic         tcpBus_rdata_ready;
    logic         tcpBus_rdata_payload_last;
    logic [127:0] tcpBus_rdata_payload_fragment;
    logic         tcpBus_rsp_valid;
    logic [1:0]   tcpBus_rsp_payload;
    // AXI write address
    logic         masterAxi_aw_valid;
    logic         masterAxi_aw_ready;
    logic [31:0]  masterAxi_aw_payload_addr;
    logic [7:0]   masterAxi_aw_payload_len;
    logic [2:0]   masterAxi_aw_payload_size;
    logic [1:0]   masterAxi_aw_payload_burst;
    // AXI write data
    logic         masterAxi_w_valid;
    logic         masterAxi_w_ready;
    logic [127:0] masterAxi_w_payload_data;
    logic [15:0]  masterAxi_w_payload_strb;
    logic         masterAxi_w_payload_last;
    // AXI write response
    logic         masterAxi_b_valid;
    logic         masterAxi_b_ready;
    logic [1:0]   masterAxi_b_payload_resp;
    // AXI read address
    logic         masterAxi_ar_valid;
    logic         masterAxi_ar_ready;
    logic [31:0]  masterAxi_ar_payload_addr;
    logic [7:0]   masterAxi_ar_payload_len;
    logic [2:0]   masterAxi_ar_payload_size;
    logic [1:0]   masterAxi_ar_payload_burst;
    // AXI read data
    logic         masterAxi_r_valid;
    logic         masterAxi_r_ready;
    logic [127:0] masterAxi_r_payload_data;
    logic [1:0]   masterAxi_r_payload_resp;
    logic         masterAxi_r_payload_last;

    // bridge view
    modport master (
        input  tcpBus_addr, tcpBus_size,
        input  tcpBus_wdata_valid, tcpBus_wdata_payload_last, tcpBus_wdata_payload_fragment,
        output tcpBus_wdata_ready,
        output tcpBus_rdata_valid, tcpBus_rdata_payload_last, tcpBus_rdata_payload_fragment,
        input  tcpBus_rdata_ready,
        output tcpBus_rsp_valid, tcpBus_rsp_payload,
        output masterAxi_aw_valid, masterAxi_aw_payload_addr, masterAxi_aw_payload_len,
        output masterAxi_aw_payload_size, masterAxi_aw_payload_burst,
        input  masterAxi_aw_ready,
        output masterAxi_w_valid, masterAxi_w_payload_data, masterAxi_w_payload_strb,
        output masterAxi_w_payload_last,
        input  masterAxi_w_ready,
        input  masterAxi_b_valid, masterAxi_b_payload_resp,
        output masterAxi_b_ready,
        output masterAxi_ar_valid, masterAxi_ar_payload_addr, masterAxi_ar_payload_len,
        output masterAxi_ar_payload_size, masterAxi_ar_payload_burst,
        input  masterAxi_ar_ready,
        input  masterAxi_r_valid, masterAxi_r_payload_data, masterAxi_r_payload_resp,
        input  masterAxi_r_payload_last,
        output masterAxi_r_ready
    );

    // host + AXI slave environment view
    modport slave (
        output tcpBus_addr, tcpBus_size,
        output tcpBus_wdata_valid, tcpBus_wdata_payload_last, tcpBus_wdata_payload_fragment,
        input  tcpBus_wdata_ready,
        input  tcpBus_rdata_valid, tcpBus_rdata_payload_last, tcpBus_rdata_payload_fragment,
        output tcpBus_rdata_ready,
        input  tcpBus_rsp_valid, tcpBus_rsp_payload,
        input  masterAxi_aw_valid, masterAxi_aw_payload_addr, masterAxi_aw_payload_len,
        input  masterAxi_aw_payload_size, masterAxi_aw_payload_burst,
        output masterAxi_aw_ready,
        input  masterAxi_w_valid, masterAxi_w_payload_data, masterAxi_w_payload_strb,
        input  masterAxi_w_payload_last,
        output masterAxi_w_ready,
        output masterAxi_b_valid, masterAxi_b_payload_resp,
        input  masterAxi_b_ready,
        input  masterAxi_ar_valid, masterAxi_ar_payload_addr, masterAxi_ar_payload_len,
        input  masterAxi_ar_payload_size, masterAxi_ar_payload_burst,
        output masterAxi_ar_ready,
        output masterAxi_r_valid, masterAxi_r_payload_data, masterAxi_r_payload_resp,
        output masterAxi_r_payload_last,
        input  masterAxi_r_ready
    );
endinterface

// File: rtl/simple_axi4_master.sv
// Bridges host command/stream bus to one-at-a-time AXI4 INCR bursts (128-bit beats).
// Latency: AW/AR one cycle after command; data beats pass through combinationally; rsp one cycle after B / last R.
// Backpressure: W and R streams pass ready straight through; address channels hold until ready; rsp is not backpressured.
module simple_axi4_master (
    input  logic                        clk,
    input  logic                        reset,
    simple_axi4_master_if.master        io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [3:0]  r_size_lo;
    logic [7:0]  r_cnt;
    logic [1:0]  r_resp;

    logic [7:0]  w_req_len;
    logic        w_start;
    logic        w_last_beat;
    logic [15:0] w_last_strb;
    logic        w_wr_fire;
    logic        w_rd_fire;

    logic        w_aw_valid;
    logic        w_w_valid;
    logic        w_b_ready;
    logic        w_ar_valid;
    logic        w_r_ready;
    logic        w_wdata_ready;
    logic        w_rdata_valid;

    // The host's own last flag is not trusted; beat counting decides the burst end.
    logic        w_unused_host_last;
    assign w_unused_host_last = io_bus.tcpBus_wdata_payload_last;

    assign w_start = io_bus.tcpBus_wdata_valid || io_bus.tcpBus_rdata_ready;

    // Burst length from byte count: ceil(size/16)-1, zero-size is one beat, oversize saturates at 256 beats.
    always_comb begin
        w_req_len = 8'd0;
        if (io_bus.tcpBus_size == 32'd0) begin
            w_req_len = 8'd0;
        end else if (io_bus.tcpBus_size > 32'd4096) begin
            w_req_len = 8'hFF;
        end else begin
            w_req_len = 8'((io_bus.tcpBus_size[11:0] - 12'd1) >> 4);
        end
    end

    assign w_last_beat = (r_cnt == r_len);
    assign w_last_strb = (r_size_lo == 4'd0) ? 16'hFFFF : ~(16'hFFFF << r_size_lo);
    assign w_wr_fire   = (r_state == S_WR_DATA) && io_bus.tcpBus_wdata_valid && io_bus.masterAxi_w_ready;
    assign w_rd_fire   = (r_state == S_RD_DATA) && io_bus.masterAxi_r_valid && io_bus.tcpBus_rdata_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next        = r_state;
        w_aw_valid    = 1'b0;
        w_w_valid     = 1'b0;
        w_b_ready     = 1'b0;
        w_ar_valid    = 1'b0;
        w_r_ready     = 1'b0;
        w_wdata_ready = 1'b0;
        w_rdata_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.tcpBus_wdata_valid) begin
                    w_next = S_WR_ADDR;
                end else if (io_bus.tcpBus_rdata_ready) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_WR_ADDR: begin
                w_aw_valid = 1'b1;
                if (io_bus.masterAxi_aw_ready) begin
                    w_next = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                w_w_valid     = io_bus.tcpBus_wdata_valid;
                w_wdata_ready = io_bus.masterAxi_w_ready;
                if (w_wr_fire && w_last_beat) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                w_b_ready = 1'b1;
                if (io_bus.masterAxi_b_valid) begin
                    w_next = S_DONE;
                end
            end
            S_RD_ADDR: begin
                w_ar_valid = 1'b1;
                if (io_bus.masterAxi_ar_ready) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_rdata_valid = io_bus.masterAxi_r_valid;
                w_r_ready     = io_bus.tcpBus_rdata_ready;
                if (w_rd_fire && io_bus.masterAxi_r_payload_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Burst context latch, beat counter and response accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_size_lo <= 4'd0;
            r_cnt     <= 8'd0;
            r_resp    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr    <= io_bus.tcpBus_addr;
                        r_len     <= w_req_len;
                        r_size_lo <= io_bus.tcpBus_size[3:0];
                        r_cnt     <= 8'd0;
                        r_resp    <= 2'd0;
                    end
                end
                S_WR_DATA: begin
                    if (w_wr_fire) begin
                        r_cnt <= w_last_beat ? 8'd0 : r_cnt + 8'd1;
                    end
                end
                S_WR_RESP: begin
                    if (io_bus.masterAxi_b_valid) begin
                        r_resp <= io_bus.masterAxi_b_payload_resp;
                    end
                end
                S_RD_DATA: begin
                    if (w_rd_fire && (io_bus.masterAxi_r_payload_resp > r_resp)) begin
                        r_resp <= io_bus.masterAxi_r_payload_resp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.masterAxi_aw_valid         = w_aw_valid;
    assign io_bus.masterAxi_aw_payload_addr  = r_addr;
    assign io_bus.masterAxi_aw_payload_len   = r_len;
    assign io_bus.masterAxi_aw_payload_size  = 3'b100;
    assign io_bus.masterAxi_aw_payload_burst = 2'b01;

    assign io_bus.masterAxi_w_valid          = w_w_valid;
    assign io_bus.masterAxi_w_payload_data   = io_bus.tcpBus_wdata_payload_fragment;
    assign io_bus.masterAxi_w_payload_strb   = w_last_beat ? w_last_strb : 16'hFFFF;
    assign io_bus.masterAxi_w_payload_last   = (r_state == S_WR_DATA) && w_last_beat;
    assign io_bus.tcpBus_wdata_ready         = w_wdata_ready;

    assign io_bus.masterAxi_b_ready          = w_b_ready;

    assign io_bus.masterAxi_ar_valid         = w_ar_valid;
    assign io_bus.masterAxi_ar_payload_addr  = r_addr;
    assign io_bus.masterAxi_ar_payload_len   = r_len;
    assign io_bus.masterAxi_ar_payload_size  = 3'b100;
    assign io_bus.masterAxi_ar_payload_burst = 2'b01;

    assign io_bus.masterAxi_r_ready             = w_r_ready;
    assign io_bus.tcpBus_rdata_valid            = w_rdata_valid;
    assign io_bus.tcpBus_rdata_payload_fragment = io_bus.masterAxi_r_payload_data;
    assign io_bus.tcpBus_rdata_payload_last     = (r_state == S_RD_DATA) && io_bus.masterAxi_r_payload_last;

    assign io_bus.tcpBus_rsp_valid   = (r_state == S_DONE);
    assign io_bus.tcpBus_rsp_payload = r_resp;

endmodule

// File: tb/tb_simple_axi4_master.sv
// Directed bench for simple_axi4_master: write/read bursts, strobes, stalls, errors, arbitration, reset abort.
// Latency: n/a.
// Backpressure: bench drives w_ready stalls, an R bubble and an AR stall.
module tb_simple_axi4_master;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    simple_axi4_master_if bus();

    simple_axi4_master dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input logic [31:0] base, input int b);
        return {4{base + 32'(b)}};
    endfunction

    // every valid/ready/last the bridge drives, packed for one-shot idle checks
    function automatic logic [9:0] outs();
        return {bus.masterAxi_aw_valid, bus.masterAxi_w_valid, bus.masterAxi_w_payload_last,
                bus.masterAxi_b_ready, bus.masterAxi_ar_valid, bus.masterAxi_r_ready,
                bus.tcpBus_wdata_ready, bus.tcpBus_rdata_valid, bus.tcpBus_rdata_payload_last,
                bus.tcpBus_rsp_valid};
    endfunction

    task automatic run_write(input string tag, input logic [31:0] addr, input logic [31:0] size,
                             input int nb, input logic [7:0] exp_len, input logic [15:0] exp_lstrb,
                             input logic [1:0] bresp, input bit stall);
        int beat;
        int guard;
        bus.tcpBus_addr                   = addr;
        bus.tcpBus_size                   = size;
        bus.tcpBus_wdata_valid            = 1'b1;
        bus.tcpBus_wdata_payload_fragment = pat(addr, 0);
        bus.masterAxi_aw_ready            = 1'b1;
        bus.masterAxi_w_ready             = 1'b0;
        cyc();
        chk({tag, "_awv"},  bus.masterAxi_aw_valid, 1'b1);
        chk({tag, "_arv"},  bus.masterAxi_ar_valid, 1'b0);
        chk({tag, "_awa"},  bus.masterAxi_aw_payload_addr, addr);
        chk({tag, "_awl"},  bus.masterAxi_aw_payload_len, exp_len);
        chk({tag, "_awsb"}, {bus.masterAxi_aw_payload_size, bus.masterAxi_aw_payload_burst}, 5'b100_01);
        cyc();
        beat  = 0;
        guard = 0;
        while (beat < nb && guard < 2 * nb + 8) begin
            bus.masterAxi_w_ready             = stall ? guard[0] : 1'b1;
            bus.tcpBus_wdata_payload_fragment = pat(addr, beat);
            bus.tcpBus_wdata_payload_last     = (beat == 0);
            #1;
            if (guard == 0) begin
                chk({tag, "_wrdy0"}, bus.tcpBus_wdata_ready, bus.masterAxi_w_ready);
                chk({tag, "_rrdy0"}, bus.masterAxi_r_ready, 1'b0);
            end
            if (bus.masterAxi_w_valid && bus.masterAxi_w_ready) begin
                chk($sformatf("%s_wd%0d", tag, beat), bus.masterAxi_w_payload_data, pat(addr, beat));
                chk($sformatf("%s_ws%0d", tag, beat), bus.masterAxi_w_payload_strb,
                    (beat == nb - 1) ? exp_lstrb : 16'hFFFF);
                chk($sformatf("%s_wl%0d", tag, beat), bus.masterAxi_w_payload_last, beat == nb - 1);
                beat++;
            end
            guard++;
            cyc();
        end
        chk({tag, "_beats"}, 128'(beat), 128'(nb));
        bus.tcpBus_wdata_valid        = 1'b0;
        bus.tcpBus_wdata_payload_last = 1'b0;
        bus.masterAxi_w_ready         = 1'b0;
        bus.masterAxi_b_valid         = 1'b1;
        bus.masterAxi_b_payload_resp  = bresp;
        #1;
        chk({tag, "_brdy"}, {bus.masterAxi_b_ready, bus.masterAxi_w_valid}, 2'b10);
        cyc();
        bus.masterAxi_b_valid        = 1'b0;
        bus.masterAxi_b_payload_resp = 2'd0;
        #1;
        chk({tag, "_rsp"}, {bus.tcpBus_rsp_valid, bus.tcpBus_rsp_payload}, {1'b1, bresp});
        cyc();
        chk({tag, "_rspoff"}, {bus.tcpBus_rsp_valid, bus.masterAxi_ar_valid}, 2'b00);
    endtask

    task automatic run_read(input string tag, input logic [31:0] addr, input logic [31:0] size,
                            input int nb, input logic [7:0] exp_len, input int err_beat,
                            input logic [1:0] err_resp, input logic [1:0] exp_resp);
        int beat;
        int guard;
        bus.tcpBus_addr        = addr;
        bus.tcpBus_size        = size;
        bus.tcpBus_rdata_ready = 1'b1;
        bus.masterAxi_ar_ready = 1'b0;
        bus.masterAxi_r_valid  = 1'b0;
        cyc();
        chk({tag, "_arv"},  bus.masterAxi_ar_valid, 1'b1);
        chk({tag, "_ara"},  bus.masterAxi_ar_payload_addr, addr);
        chk({tag, "_arl"},  bus.masterAxi_ar_payload_len, exp_len);
        chk({tag, "_arsb"}, {bus.masterAxi_ar_payload_size, bus.masterAxi_ar_payload_burst}, 5'b100_01);
        cyc();
        chk({tag, "_arhold"}, {bus.masterAxi_ar_valid, bus.masterAxi_ar_payload_addr}, {1'b1, addr});
        bus.masterAxi_ar_ready = 1'b1;
        cyc();
        bus.masterAxi_ar_ready = 1'b0;
        beat  = 0;
        guard = 0;
        while (beat < nb && guard < 2 * nb + 8) begin
            bus.masterAxi_r_valid        = (guard != 1);
            bus.masterAxi_r_payload_data = pat(addr, beat);
            bus.masterAxi_r_payload_resp = (beat == err_beat) ? err_resp : 2'd0;
            bus.masterAxi_r_payload_last = (beat == nb - 1);
            #1;
            if (guard == 0) chk({tag, "_rrdy"}, bus.masterAxi_r_ready, 1'b1);
            if (guard == 1) chk({tag, "_bubble"}, bus.tcpBus_rdata_valid, 1'b0);
            if (bus.masterAxi_r_valid) begin
                chk($sformatf("%s_rv%0d", tag, beat), bus.tcpBus_rdata_valid, 1'b1);
                chk($sformatf("%s_rd%0d", tag, beat), bus.tcpBus_rdata_payload_fragment, pat(addr, beat));
                chk($sformatf("%s_rl%0d", tag, beat), bus.tcpBus_rdata_payload_last, beat == nb - 1);
                beat++;
            end
            guard++;
            cyc();
        end
        chk({tag, "_beats"}, 128'(beat), 128'(nb));
        bus.masterAxi_r_valid        = 1'b0;
        bus.masterAxi_r_payload_last = 1'b0;
        bus.masterAxi_r_payload_resp = 2'd0;
        bus.tcpBus_rdata_ready       = 1'b0;
        #1;
        chk({tag, "_rsp"}, {bus.tcpBus_rsp_valid, bus.tcpBus_rsp_payload}, {1'b1, exp_resp});
        cyc();
        chk({tag, "_rspoff"}, bus.tcpBus_rsp_valid, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        bus.tcpBus_addr                   = 32'd0;
        bus.tcpBus_size                   = 32'd0;
        bus.tcpBus_wdata_valid            = 1'b0;
        bus.tcpBus_wdata_payload_last     = 1'b0;
        bus.tcpBus_wdata_payload_fragment = 128'd0;
        bus.tcpBus_rdata_ready            = 1'b0;
        bus.masterAxi_aw_ready            = 1'b0;
        bus.masterAxi_w_ready             = 1'b0;
        bus.masterAxi_b_valid             = 1'b0;
        bus.masterAxi_b_payload_resp      = 2'd0;
        bus.masterAxi_ar_ready            = 1'b0;
        bus.masterAxi_r_valid             = 1'b0;
        bus.masterAxi_r_payload_data      = 128'd0;
        bus.masterAxi_r_payload_resp      = 2'd0;
        bus.masterAxi_r_payload_last      = 1'b0;

        repeat (3) cyc();
        chk("rst_outs", outs(), 10'd0);
        chk("rst_resp", bus.tcpBus_rsp_payload, 2'd0);
        reset = 1'b0;
        cyc();
        chk("idle_outs", outs(), 10'd0);

        // single-beat write, OKAY
        run_write("w16", 32'h100, 32'd16, 1, 8'd0, 16'hFFFF, 2'd0, 1'b0);
        // four-beat read, OKAY
        run_read("r64", 32'h200, 32'd64, 4, 8'd3, -1, 2'd0, 2'd0);
        // three-beat write, partial last strobe, w_ready toggling
        run_write("w40", 32'h300, 32'd40, 3, 8'd2, 16'h00FF, 2'd0, 1'b1);
        // read with SLVERR on second beat
        run_read("rerr", 32'h400, 32'd32, 2, 8'd1, 1, 2'd2, 2'd2);
        // write with DECERR response
        run_write("wdec", 32'h600, 32'd16, 1, 8'd0, 16'hFFFF, 2'd3, 1'b0);
        // zero size is one full beat; 17 bytes is two beats with a one-byte tail
        run_write("w0", 32'h700, 32'd0, 1, 8'd0, 16'hFFFF, 2'd0, 1'b0);
        run_write("w17", 32'h800, 32'd17, 2, 8'd1, 16'h0001, 2'd0, 1'b0);
        // oversize read saturates to 256 beats
        run_read("rsat", 32'h1000, 32'd5000, 256, 8'hFF, -1, 2'd0, 2'd0);

        // write and read requested together: write first, read after its rsp pulse
        bus.tcpBus_rdata_ready = 1'b1;
        run_write("both_w", 32'h900, 32'd32, 2, 8'd1, 16'hFFFF, 2'd1, 1'b0);
        run_read("both_r", 32'hA00, 32'd16, 1, 8'd0, -1, 2'd0, 2'd0);

        // reset during WR_DATA aborts the burst
        bus.tcpBus_addr        = 32'h500;
        bus.tcpBus_size        = 32'd48;
        bus.tcpBus_wdata_valid = 1'b1;
        bus.masterAxi_aw_ready = 1'b1;
        bus.masterAxi_w_ready  = 1'b1;
        cyc();
        cyc();
        chk("abort_wv", bus.masterAxi_w_valid, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        chk("abort_outs", outs(), 10'd0);
        reset                  = 1'b0;
        bus.tcpBus_wdata_valid = 1'b0;
        bus.masterAxi_w_ready  = 1'b0;
        cyc();
        chk("abort_idle", outs(), 10'd0);
        cyc();
        chk("abort_norsp", outs(), 10'd0);
        run_write("post", 32'hB00, 32'd24, 2, 8'd1, 16'h00FF, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
